bp_update_arb: RTL and testbench
================================

BP_UPDATE_ARB -- requirements
Module: bp_update_arb

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the queue entry count (power of two, >=2).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the drop counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low (rst=0 at a rising edge resets).
REQ-005 in0_valid  input  1  SHALL mark a resolved branch from execute pipe 0 (older slot).
REQ-006 in0_pc / in0_target  input  32 each  SHALL carry the branch PC / actual target for pipe 0.
REQ-007 in0_taken  input  1  SHALL carry the actual direction for pipe 0.
REQ-008 in1_valid, in1_pc, in1_taken, in1_target  input  1/32/1/32  SHALL be the same fields for pipe 1 (younger slot).
REQ-009 in_ready  output  1  SHALL indicate that both slots can be accepted this cycle.
REQ-010 flush  input  1  SHALL discard all queued and incoming resolutions.
REQ-011 hold  input  1  SHALL block draining this cycle (predictor tables busy).
REQ-012 update  output  1  SHALL drive the predictor update strobe.
REQ-013 update_pc, act_taken, act_target  output  32/1/32  SHALL drive the predictor update fields.
REQ-014 q_count  output  $clog2(DEPTH)+1  SHALL report the number of queued entries.
REQ-015 drop_cnt  output  CNT_W  SHALL count discarded resolutions.

Function
REQ-016 Storage SHALL be a circular FIFO of DEPTH entries {pc, taken, target} with registered head pointer, tail pointer, and count; pointers wrap modulo DEPTH.
REQ-017 in_ready SHALL be combinational from registered count: 1 iff DEPTH - count >= 2.
REQ-018 When in_ready=1 and flush=0, valid slots SHALL be pushed in order: in0 at tail, then in1 at the next slot; if only in1 is valid it SHALL take the tail slot.
REQ-019 When in_ready=0 and flush=0, each valid slot SHALL be dropped and drop_cnt incremented by the number dropped (0/1/2).
REQ-020 drop_cnt SHALL saturate at all-ones and never wrap.
REQ-021 update SHALL be 1 iff count != 0, hold=0 and flush=0; update_pc/act_taken/act_target SHALL reflect the head entry combinationally.
REQ-022 When update=1, the head SHALL be popped at the clock edge; one pop per cycle maximum.
REQ-023 Push and pop in the same cycle SHALL both take effect; next count = count + pushes - pop.
REQ-024 Latency: an entry pushed at edge N into an empty queue SHALL appear on update in the cycle after edge N; the queue has no bypass path.
REQ-025 Drain order SHALL be strict FIFO; entries of a cycle drain in0 before in1.
REQ-026 When update=0, update_pc/act_taken/act_target SHALL be don't-care to consumers, but SHALL NOT be X after reset (storage reset to 0).
REQ-027 flush=1 SHALL set count, head and tail to 0 at the edge, discard that cycle's inputs without incrementing drop_cnt, and force update=0 in that cycle.
REQ-028 flush SHALL take priority over hold, push, and pop.
REQ-029 hold=1 SHALL freeze the head pointer; pushes continue per REQ-017..019.
REQ-030 Count SHALL never exceed DEPTH or underflow; in_ready=0 at count >= DEPTH-1 guarantees this.

Reset
REQ-031 rst=0 at an edge SHALL clear head, tail, count, drop_cnt and all entry storage to 0.
REQ-032 During and after reset: update=0, q_count=0, in_ready=1, drop_cnt=0.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries with no update emitted in the reset cycle or the cycle after it.
REQ-034 Reset SHALL take priority over flush, hold, and all inputs.

Verification
REQ-035 Reset release; in0 {pc=0x1000, taken=1, target=0x2000} one cycle -> next cycle update=1 with those values; following cycle update=0, q_count=0.
REQ-036 in0 pc=0x10, in1 pc=0x20 in the same cycle, hold=0 -> update pc=0x10, then pc=0x20 on consecutive cycles.
REQ-037 hold=1, both slots valid every cycle (DEPTH=4) -> q_count 2, then 4; in_ready=0 at count>=3; third cycle drops two entries (drop_cnt=2); release hold -> four ordered updates.
REQ-038 Queue count=3 with flush=1 and in0_valid=1 -> update=0 that cycle; next cycle q_count=0, drop_cnt unchanged.
REQ-039 Force 300 drops with CNT_W=8 -> drop_cnt saturates at 255.
REQ-040 rst=0 with count=2 mid-drain -> update=0 in the reset cycle and the cycle after; q_count=0 and in_ready=1 after reset.

Source files
------------

// File: rtl/bp_update_arb_if.sv
// rtl/bp_update_arb_if.sv - resolved-branch input slots and predictor update bus
interface bp_update_arb_if;
    logic        in0_valid;
    logic [31:0] in0_pc;
    logic        in0_taken;
    logic [31:0] in0_target;
    logic        in1_valid;
    logic [31:0] in1_pc;
    logic        in1_taken;
    logic [31:0] in1_target;
    logic        in_ready;
    logic        update;
    logic [31:0] update_pc;
    logic        act_taken;
    logic [31:0] act_target;

    modport master (
        output in0_valid, in0_pc, in0_taken, in0_target,
        output in1_valid, in1_pc, in1_taken, in1_target,
        input  in_ready, update, update_pc, act_taken, act_target
    );

    modport slave (
        input  in0_valid, in0_pc, in0_taken, in0_target,
        input  in1_valid, in1_pc, in1_taken, in1_target,
        output in_ready, update, update_pc, act_taken, act_target
    );
endinterface

// File: rtl/bp_update_arb.sv
// rtl/bp_update_arb.sv - two-slot branch resolution queue feeding one predictor update port
module bp_update_arb #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       hold,
    bp_update_arb_if.slave             bus,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [CNT_W-1:0]           drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int QW = AW + 1;

    logic [31:0]    r_pc  [DEPTH];
    logic           r_tk  [DEPTH];
    logic [31:0]    r_tg  [DEPTH];
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [QW-1:0]  r_count;
    logic [CNT_W-1:0] r_drop;

    logic           w_ready;
    logic           w_pop;
    logic           w_push0;
    logic           w_push1;
    logic [1:0]     w_n_push;
    logic [1:0]     w_n_drop;
    logic [AW-1:0]  w_slot1;
    logic [CNT_W:0] w_drop_sum;
    logic [CNT_W-1:0] w_drop_nxt;

    // Accept only when both slots fit, so a pair is never split across cycles.
    assign w_ready  = (r_count <= QW'(DEPTH - 2));
    assign w_pop    = rst && !flush && !hold && (r_count != '0);
    assign w_push0  = w_ready && !flush && bus.in0_valid;
    assign w_push1  = w_ready && !flush && bus.in1_valid;
    assign w_n_push = {1'b0, w_push0} + {1'b0, w_push1};
    assign w_n_drop = (!w_ready && !flush) ? ({1'b0, bus.in0_valid} + {1'b0, bus.in1_valid}) : 2'd0;
    assign w_slot1  = w_push0 ? (r_tail + AW'(1)) : r_tail;

    assign w_drop_sum = {1'b0, r_drop} + (CNT_W+1)'(w_n_drop);
    assign w_drop_nxt = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_drop  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i] <= '0;
                r_tk[i] <= 1'b0;
                r_tg[i] <= '0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push0) begin
                r_pc[r_tail] <= bus.in0_pc;
                r_tk[r_tail] <= bus.in0_taken;
                r_tg[r_tail] <= bus.in0_target;
            end
            if (w_push1) begin
                r_pc[w_slot1] <= bus.in1_pc;
                r_tk[w_slot1] <= bus.in1_taken;
                r_tg[w_slot1] <= bus.in1_target;
            end
            r_tail  <= r_tail + AW'(w_n_push);
            if (w_pop)
                r_head <= r_head + AW'(1);
            r_count <= r_count + QW'(w_n_push) - QW'(w_pop);
            r_drop  <= w_drop_nxt;
        end
    end

    // Outputs are masked while reset is held so no stale entry leaks out.
    assign bus.in_ready   = w_ready || !rst;
    assign bus.update     = w_pop;
    assign bus.update_pc  = r_pc[r_head];
    assign bus.act_taken  = r_tk[r_head];
    assign bus.act_target = r_tg[r_head];
    assign q_count        = rst ? r_count : '0;
    assign drop_cnt       = r_drop;
endmodule

// File: tb/tb_bp_update_arb.sv
// tb/tb_bp_update_arb.sv - directed self-checking bench for bp_update_arb
module tb_bp_update_arb;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       hold;
    logic [2:0] q_count;
    logic [7:0] drop_cnt;
    int         n_chk  = 0;
    int         n_pass = 0;

    bp_update_arb_if u_if ();

    bp_update_arb #(.DEPTH(4), .CNT_W(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .hold     (hold),
        .bus      (u_if.slave),
        .q_count  (q_count),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        u_if.in0_valid = v; u_if.in0_pc = pc; u_if.in0_taken = tk; u_if.in0_target = tg;
    endtask

    task automatic set1(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        u_if.in1_valid = v; u_if.in1_pc = pc; u_if.in1_taken = tk; u_if.in1_target = tg;
    endtask

    task automatic chk_upd(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        check({tag, "_update"}, {31'd0, u_if.update}, 32'd1);
        check({tag, "_pc"}, u_if.update_pc, pc);
        check({tag, "_taken"}, {31'd0, u_if.act_taken}, {31'd0, tk});
        check({tag, "_target"}, u_if.act_target, tg);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; hold = 1'b0;
        set0(1'b1, 32'hdead, 1'b1, 32'hbeef);
        set1(1'b1, 32'hdead, 1'b1, 32'hbeef);
        tick(); tick();
        check("rst_update", {31'd0, u_if.update}, 32'd0);
        check("rst_qcount", {29'd0, q_count}, 32'd0);
        check("rst_in_ready", {31'd0, u_if.in_ready}, 32'd1);
        check("rst_drop", {24'd0, drop_cnt}, 32'd0);
        check("rst_pc_zero", u_if.update_pc, 32'd0);

        // single in0 entry, one-cycle latency
        rst = 1'b1;
        set0(1'b1, 32'h1000, 1'b1, 32'h2000);
        set1(1'b0, 32'h0, 1'b0, 32'h0);
        #1 check("lat_pre_update", {31'd0, u_if.update}, 32'd0);
        tick();
        set0(1'b0, 32'h0, 1'b0, 32'h0);
        #1 chk_upd("lat", 32'h1000, 1'b1, 32'h2000);
        check("lat_q1", {29'd0, q_count}, 32'd1);
        tick();
        check("lat_post_update", {31'd0, u_if.update}, 32'd0);
        check("lat_post_q", {29'd0, q_count}, 32'd0);

        // pair in one cycle drains in0 then in1
        set0(1'b1, 32'h10, 1'b0, 32'h11);
        set1(1'b1, 32'h20, 1'b1, 32'h21);
        tick();
        set0(1'b0, 32'h0, 1'b0, 32'h0);
        set1(1'b0, 32'h0, 1'b0, 32'h0);
        #1 chk_upd("pair0", 32'h10, 1'b0, 32'h11);
        check("pair_q2", {29'd0, q_count}, 32'd2);
        tick();
        chk_upd("pair1", 32'h20, 1'b1, 32'h21);
        tick();
        check("pair_empty", {29'd0, q_count}, 32'd0);

        // hold fills queue, third pair dropped, then ordered drain
        hold = 1'b1;
        set0(1'b1, 32'h100, 1'b0, 32'h1100);
        set1(1'b1, 32'h101, 1'b1, 32'h1101);
        tick();
        check("fill_q2", {29'd0, q_count}, 32'd2);
        check("fill_ready_q2", {31'd0, u_if.in_ready}, 32'd1);
        check("hold_no_update", {31'd0, u_if.update}, 32'd0);
        set0(1'b1, 32'h102, 1'b1, 32'h1102);
        set1(1'b1, 32'h103, 1'b0, 32'h1103);
        tick();
        check("fill_q4", {29'd0, q_count}, 32'd4);
        check("fill_ready_q4", {31'd0, u_if.in_ready}, 32'd0);
        set0(1'b1, 32'h1ee, 1'b1, 32'h1ee);
        set1(1'b1, 32'h1ef, 1'b1, 32'h1ef);
        tick();
        check("drop_two", {24'd0, drop_cnt}, 32'd2);
        check("drop_q4", {29'd0, q_count}, 32'd4);
        set0(1'b0, 32'h0, 1'b0, 32'h0);
        set1(1'b0, 32'h0, 1'b0, 32'h0);
        hold = 1'b0;
        #1 chk_upd("drain0", 32'h100, 1'b0, 32'h1100);
        tick();
        chk_upd("drain1", 32'h101, 1'b1, 32'h1101);
        check("drain_ready_q3", {31'd0, u_if.in_ready}, 32'd0);
        tick();
        chk_upd("drain2", 32'h102, 1'b1, 32'h1102);
        check("drain_ready_q2", {31'd0, u_if.in_ready}, 32'd1);
        tick();
        chk_upd("drain3", 32'h103, 1'b0, 32'h1103);
        tick();
        check("drain_empty_update", {31'd0, u_if.update}, 32'd0);

        // flush at count 3 with in0 valid
        hold = 1'b1;
        set0(1'b1, 32'h200, 1'b0, 32'h0);
        set1(1'b1, 32'h201, 1'b0, 32'h0);
        tick();
        set1(1'b0, 32'h0, 1'b0, 32'h0);
        set0(1'b1, 32'h202, 1'b0, 32'h0);
        tick();
        check("flush_pre_q3", {29'd0, q_count}, 32'd3);
        check("flush_pre_ready", {31'd0, u_if.in_ready}, 32'd0);
        flush = 1'b1; hold = 1'b0;
        #1 check("flush_update", {31'd0, u_if.update}, 32'd0);
        tick();
        flush = 1'b0;
        set0(1'b0, 32'h0, 1'b0, 32'h0);
        #1 check("flush_q0", {29'd0, q_count}, 32'd0);
        check("flush_drop_kept", {24'd0, drop_cnt}, 32'd2);

        // lone in1 takes the tail slot
        set1(1'b1, 32'h300, 1'b1, 32'h301);
        tick();
        set1(1'b0, 32'h0, 1'b0, 32'h0);
        #1 chk_upd("in1_only", 32'h300, 1'b1, 32'h301);
        tick();

        // drop counter saturation: 150 full-queue pairs on top of 2
        hold = 1'b1;
        set0(1'b1, 32'h400, 1'b0, 32'h0);
        set1(1'b1, 32'h401, 1'b0, 32'h0);
        tick(); tick();
        for (int k = 0; k < 126; k++) tick();
        check("sat_254", {24'd0, drop_cnt}, 32'd254);
        tick();
        check("sat_255", {24'd0, drop_cnt}, 32'd255);
        for (int k = 0; k < 23; k++) tick();
        check("sat_hold", {24'd0, drop_cnt}, 32'd255);
        set0(1'b0, 32'h0, 1'b0, 32'h0);
        set1(1'b0, 32'h0, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // reset mid-drain at count 2
        set0(1'b1, 32'h500, 1'b0, 32'h5);
        set1(1'b1, 32'h501, 1'b1, 32'h6);
        tick();
        set0(1'b0, 32'h0, 1'b0, 32'h0);
        set1(1'b0, 32'h0, 1'b0, 32'h0);
        hold = 1'b0;
        #1 chk_upd("mid_drain", 32'h500, 1'b0, 32'h5);
        rst = 1'b0;
        #1 check("mrst_update", {31'd0, u_if.update}, 32'd0);
        check("mrst_q", {29'd0, q_count}, 32'd0);
        check("mrst_ready", {31'd0, u_if.in_ready}, 32'd1);
        tick();
        rst = 1'b1;
        #1 check("post_rst_update", {31'd0, u_if.update}, 32'd0);
        check("post_rst_q", {29'd0, q_count}, 32'd0);
        check("post_rst_ready", {31'd0, u_if.in_ready}, 32'd1);
        check("post_rst_drop", {24'd0, drop_cnt}, 32'd0);
        tick();
        check("post_rst_update2", {31'd0, u_if.update}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
